// File: rtl/dynamic_port_arb_mux.sv
// Round-robin wormhole arbiter/mux: N credit-flow input channels onto one credited output.
// A header with a nonzero length field locks the grant until that many body flits have passed.
module dynamic_port_arb_mux #(
    parameter int WIDTH   = 64,
    parameter int NUM_IN  = 5,
    parameter int SEL_W   = 3,
    parameter int LEN_LSB = 22,
    parameter int LEN_W   = 8,
    parameter int CREDITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_yummy,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_yummy,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    busy
);
    localparam int CNT_W = 4;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_reg;
    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [LEN_W-1:0]  rem_reg;
    logic [CNT_W-1:0]  credit_reg;
    logic [CNT_W-1:0]  credit_next;
    logic [WIDTH-1:0]  out_data_reg;
    logic              out_valid_reg;

    logic [WIDTH-1:0]  chan_data [NUM_IN];
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_found;
    logic [SEL_W-1:0]  xfer_sel;
    logic              xfer;
    logic [LEN_W-1:0]  hdr_len;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (int'(v) == NUM_IN - 1) ? '0 : v + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign in_yummy[gi]  = xfer && (xfer_sel == SEL_W'(gi));
        end
    endgenerate

    // Scan downward so the candidate closest to the pointer is written last and wins.
    always_comb begin
        grant_idx   = ptr_reg;
        grant_found = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            int               sum;
            logic [SEL_W-1:0] cand;
            sum = int'(ptr_reg) + i;
            if (sum >= NUM_IN)
                sum = sum - NUM_IN;
            cand = SEL_W'(sum);
            if (in_valid[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        xfer_sel = (state_reg == IDLE) ? grant_idx : sel_reg;
        xfer     = !reset && (credit_reg != '0) &&
                   ((state_reg == IDLE) ? grant_found : in_valid[sel_reg]);
        hdr_len  = chan_data[grant_idx][LEN_LSB +: LEN_W];
    end

    // A returned credit and a spent credit in the same cycle cancel out.
    always_comb begin
        credit_next = credit_reg;
        case ({xfer, out_yummy})
            2'b10:   credit_next = credit_reg - 1'b1;
            2'b01:   credit_next = (credit_reg == CNT_W'(CREDITS)) ? credit_reg : credit_reg + 1'b1;
            default: credit_next = credit_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            sel_reg       <= '0;
            rem_reg       <= '0;
            credit_reg    <= CNT_W'(CREDITS);
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            credit_reg    <= credit_next;
            out_valid_reg <= xfer;
            if (xfer) begin
                out_data_reg <= chan_data[xfer_sel];
                if (state_reg == IDLE) begin
                    sel_reg <= grant_idx;
                    rem_reg <= hdr_len;
                    if (hdr_len == '0)
                        ptr_reg <= wrap_inc(grant_idx);
                    else
                        state_reg <= LOCKED;
                end else begin
                    rem_reg <= rem_reg - 1'b1;
                    if (rem_reg == LEN_W'(1)) begin
                        state_reg <= IDLE;
                        ptr_reg   <= wrap_inc(sel_reg);
                    end
                end
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign cur_sel   = sel_reg;
    assign busy      = (state_reg == LOCKED);
endmodule

// File: tb/tb_dynamic_port_arb_mux.sv
// Randomized bench for dynamic_port_arb_mux: a packet-level reference model predicts each
// grant; a scoreboard queue carries expected flits to an independent output monitor.
module tb_dynamic_port_arb_mux;
    localparam int WIDTH   = 64;
    localparam int NUM_IN  = 5;
    localparam int SEL_W   = 3;
    localparam int LEN_LSB = 22;
    localparam int LEN_W   = 8;
    localparam int CREDITS = 4;
    localparam int NCYC    = 3000;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_yummy;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_yummy;
    logic [SEL_W-1:0]        cur_sel;
    logic                    busy;

    dynamic_port_arb_mux #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W),
        .LEN_LSB(LEN_LSB), .LEN_W(LEN_W), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_yummy(in_yummy), .out_data(out_data), .out_valid(out_valid),
        .out_yummy(out_yummy), .cur_sel(cur_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] pend [NUM_IN];

    // Packet-level reference state: who owns the output, how many body flits remain.
    int m_ptr, m_cur, m_rem, m_credit;
    bit m_locked;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] new_flit();
        logic [WIDTH-1:0] f;
        f = {$urandom, $urandom};
        f[LEN_LSB +: LEN_W] = ($urandom_range(0, 9) < 4) ? 8'd0 : 8'($urandom_range(1, 3));
        return f;
    endfunction

    // Output monitor: every presented flit must be the oldest predicted one.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got %h expected no flit at %0t", out_data, $time);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        bit prev_rst;
        prev_rst = 1'b0;
        m_ptr = 0; m_cur = 0; m_rem = 0; m_credit = CREDITS; m_locked = 0;
        for (int i = 0; i < NUM_IN; i++) pend[i] = new_flit();
        reset = 1'b1; in_valid = '0; out_yummy = 1'b0; in_data = '0;

        for (int cyc = 0; cyc < NCYC + 6; cyc++) begin
            int xch;
            bit xf;
            @(negedge clk);
            if (cyc > 0) begin
                check("busy", {63'd0, busy}, {63'd0, m_locked});
                check("cur_sel", {61'd0, cur_sel}, 64'(m_cur));
            end
            if (prev_rst) begin
                check("rst_out_valid", {63'd0, out_valid}, 64'd0);
                check("rst_out_data", out_data, 64'd0);
            end

            reset = (cyc < 2) || (cyc < NCYC && $urandom_range(0, 199) == 0);
            for (int i = 0; i < NUM_IN; i++) begin
                in_data[i*WIDTH +: WIDTH] = pend[i];
                in_valid[i] = (cyc < NCYC) && ($urandom_range(0, 9) < 7);
            end
            if (cyc >= NCYC)
                out_yummy = 1'b1;
            else if ((cyc / 400) % 2 == 1)
                out_yummy = ($urandom_range(0, 5) == 0);
            else
                out_yummy = $urandom_range(0, 1);
            #1;

            xf = 0; xch = 0;
            if (!reset && m_credit > 0) begin
                if (!m_locked) begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        int c;
                        c = (m_ptr + k) % NUM_IN;
                        if (!xf && in_valid[c]) begin
                            xf = 1; xch = c;
                        end
                    end
                end else if (in_valid[m_cur]) begin
                    xf = 1; xch = m_cur;
                end
            end
            check("in_yummy", {59'd0, in_yummy}, xf ? 64'(1 << xch) : 64'd0);

            if (reset) begin
                m_ptr = 0; m_cur = 0; m_rem = 0; m_credit = CREDITS; m_locked = 0;
            end else begin
                if (xf) begin
                    exp_q.push_back(pend[xch]);
                    if (!m_locked) begin
                        m_cur = xch;
                        m_rem = int'(pend[xch][LEN_LSB +: LEN_W]);
                        if (m_rem == 0) m_ptr = (xch + 1) % NUM_IN;
                        else m_locked = 1;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_locked = 0;
                            m_ptr = (m_cur + 1) % NUM_IN;
                        end
                    end
                    pend[xch] = new_flit();
                end
                m_credit = m_credit - int'(xf) + int'(out_yummy);
                if (m_credit > CREDITS) m_credit = CREDITS;
            end
            prev_rst = reset;
        end

        @(negedge clk);
        #2;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
